// File: rtl/v810_pkg.sv
// Shared types and constants for the V810 external-bus cycle controller.
package v810_pkg;

  localparam int unsigned NUM_BUS_REGIONS = 8;

  // Bit order matches CFG_D: [5] ext_en, [4] bus16, [3:0] wait states.
  typedef struct packed {
    logic       ext_en;
    logic       bus16;
    logic [3:0] waits;
  } bus_region_cfg_t;

  localparam bus_region_cfg_t BUS_CFG_RST = '{ext_en: 1'b0, bus16: 1'b0, waits: 4'd3};

  typedef enum logic [0:0] {
    StIdle,
    StData
  } bctl_st_t;

  function automatic logic [NUM_BUS_REGIONS-1:0] region_onehot(input logic [2:0] region);
    logic [NUM_BUS_REGIONS-1:0] oh;
    oh = '0;
    oh[region] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/v810_bus_region_cfg.sv
// Per-region bus timing configuration: one write port, one combinational read port.
module v810_bus_region_cfg
  import v810_pkg::*;
(
  input  logic            CLK,
  input  logic            RES,
  input  logic            CE,
  input  logic            wr_i,
  input  logic [2:0]      wsel_i,
  input  bus_region_cfg_t wdata_i,
  input  logic [2:0]      rsel_i,
  output bus_region_cfg_t rdata_o
);

  bus_region_cfg_t cfg_q [NUM_BUS_REGIONS];

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (RES) begin
        for (int i = 0; i < NUM_BUS_REGIONS; i++) begin
          cfg_q[i] <= BUS_CFG_RST;
        end
      end else if (wr_i) begin
        cfg_q[wsel_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = cfg_q[rsel_i];

endmodule

// File: rtl/v810_bus_ctrl.sv
// V810 external-bus cycle controller: region decode, wait states, dynamic sizing and
// device-ready handling with a timeout backstop.
module v810_bus_ctrl
  import v810_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned REGION_MSB     = 26
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic        BCYSTn,
  input  logic        DAn,
  input  logic        MRQn,
  input  logic        RW,
  output logic        READYn,
  output logic        SZRQn,
  input  logic [7:0]  DEV_RDYn,
  output logic [7:0]  CS,
  output logic        CS_RD,
  output logic        CS_WR,
  input  logic        CFG_WR,
  input  logic [2:0]  CFG_SEL,
  input  logic [5:0]  CFG_D,
  output logic        TIMEOUT
);

  localparam int unsigned TcntW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TcntW-1:0] TcntMax = TcntW'(TIMEOUT_CYCLES);

  bctl_st_t        st_q, st_d;
  logic [2:0]      region_q, region_d;
  bus_region_cfg_t snap_q, snap_d;
  logic            mem_q, mem_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;

  logic [2:0]      a_region;
  bus_region_cfg_t a_cfg;
  logic            t1, in_data, dphase, rdy, tout_hit, done;
  logic            unused_a;

  assign a_region = A[REGION_MSB -: 3];
  assign unused_a = ^A;

  v810_bus_region_cfg u_cfg (
    .CLK     (CLK),
    .RES     (RES),
    .CE      (CE),
    .wr_i    (CFG_WR),
    .wsel_i  (CFG_SEL),
    .wdata_i (bus_region_cfg_t'(CFG_D)),
    .rsel_i  (a_region),
    .rdata_o (a_cfg)
  );

  // A start strobe always wins over a concurrent data strobe.
  assign t1       = ~BCYSTn;
  assign in_data  = (st_q == StData);
  assign dphase   = in_data & ~DAn & ~t1;
  assign rdy      = (wcnt_q == 4'd0) & (~snap_q.ext_en | ~DEV_RDYn[region_q]);
  assign tout_hit = (tcnt_q == TcntMax);
  assign done     = dphase & (rdy | tout_hit);

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (RES) begin
        st_q     <= StIdle;
        region_q <= 3'd0;
        snap_q   <= BUS_CFG_RST;
        mem_q    <= 1'b0;
        wcnt_q   <= 4'd0;
        tcnt_q   <= '0;
      end else begin
        st_q     <= st_d;
        region_q <= region_d;
        snap_q   <= snap_d;
        mem_q    <= mem_d;
        wcnt_q   <= wcnt_d;
        tcnt_q   <= tcnt_d;
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    region_d = region_q;
    snap_d   = snap_q;
    mem_d    = mem_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    if (t1) begin
      // Snapshot taken here, so a same-cycle config write only affects later cycles.
      st_d     = StData;
      region_d = a_region;
      snap_d   = a_cfg;
      mem_d    = ~MRQn;
      wcnt_d   = a_cfg.waits;
      tcnt_d   = '0;
    end else if (in_data && !DAn) begin
      if (rdy || tout_hit) begin
        st_d = StIdle;
      end else begin
        wcnt_d = (wcnt_q == 4'd0) ? 4'd0 : wcnt_q - 4'd1;
        tcnt_d = tcnt_q + TcntW'(1);
      end
    end
  end

  always_comb begin
    READYn  = ~done;
    TIMEOUT = dphase & tout_hit & ~rdy;

    SZRQn = 1'b1;
    if (t1) begin
      SZRQn = ~a_cfg.bus16;
    end else if (in_data) begin
      SZRQn = ~snap_q.bus16;
    end

    CS = '0;
    if (t1) begin
      if (!MRQn) begin
        CS = region_onehot(a_region);
      end
    end else if (in_data && mem_q) begin
      CS = region_onehot(region_q);
    end
    CS_RD = (|CS) & RW;
    CS_WR = (|CS) & ~RW;
  end

endmodule

// File: doc/v810_bus_ctrl.md
# v810_bus_ctrl

External-bus cycle controller for the V810 core. It sits on the external side of `v810_mem`, decodes each bus cycle's address into one of eight regions, and drives `READYn` and `SZRQn` back to the core. The number of wait states, the 16-bit dynamic sizing and the use of a device-supplied ready are programmable per region, so memory and peripheral timing are configured here and not in each device model.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of data-phase CE cycles after which ready is forced.
- `REGION_MSB`, default 26: region select is `A[REGION_MSB:REGION_MSB-2]`.

Ports (all sequential logic is clocked on `CLK` and qualified by `CE`):
- `CLK`  in  1: single clock.
- `RES`  in  1: reset, synchronous, active-high, sampled when `CE`=1.
- `CE`  in  1: global clock enable, same as the core's.
- `A`  in  32: bus address from the core.
- `BCYSTn`  in  1: bus cycle start, low in T1/T1S.
- `DAn`  in  1: data access, low in T2/T2S.
- `MRQn`  in  1: memory request; I/O cycles have `MRQn`=1.
- `RW`  in  1: 1 = read. Routed to `CS_RD`/`CS_WR` only.
- `READYn`  out  1: cycle-end ready to the core.
- `SZRQn`  out  1: 16-bit sizing request to the core.
- `DEV_RDYn`  in  8: per-region device ready, active-low.
- `CS`  out  8: one-hot region select, valid from T1 to the end of data.
- `CS_RD`, `CS_WR`  out  1 each: `CS` is active and `RW`=1 or `RW`=0.
- `CFG_WR`  in  1: configuration write strobe.
- `CFG_SEL`  in  3: index of the region written.
- `CFG_D`  in  6: `[3:0]` wait states, `[4]` bus16, `[5]` ext_ready enable.
- `TIMEOUT`  out  1: one-CE-cycle pulse when a cycle is ended by the timeout.

## Operation
- Config file: 8 entries of {wait[3:0], bus16, ext_en}.
  - Written on a CE cycle with `CFG_WR`=1.
  - Reset value of every entry: wait=3, bus16=0, ext_en=0.
- FSM states:
  - ST_IDLE: no cycle in progress.
  - ST_DATA: T2/T2S data phase.
- ST_IDLE to ST_DATA: on a CE cycle with `BCYSTn`=0.
  - Latch the region from `A`.
  - Latch a snapshot of that region's config entry.
  - Load `wcnt` with the wait-state value; clear `tcnt`.
- The same transition occurs in ST_DATA if `BCYSTn`=0. This is the T1S of the second halfword, which reloads from the same region.
- In ST_DATA, per CE cycle with `DAn`=0:
  - `rdy` = (`wcnt`==0) & (~ext_en | ~`DEV_RDYn[region]`).
  - If `rdy`, or `tcnt`==`TIMEOUT_CYCLES`: the cycle ends and the FSM returns to ST_IDLE.
  - Otherwise: `wcnt` decrements, saturating at 0; `tcnt` increments.
- A config write during a cycle affects only later cycles, because the snapshot is taken at T1.
  - A write to the active region in the same CE cycle as `BCYSTn`=0 uses the old value.
- `CS`, `CS_RD` and `CS_WR` are driven only for MRQn=0 cycles. For I/O cycles, `CS`=0 but `READYn` is still generated from the region config.

## Timing
- `READYn` is combinational from registered state, `DEV_RDYn` and the timeout compare.
  - It is stable for the whole CLK period, because the core samples it on the `CE`=0 phase.
  - `READYn`=0 only in ST_DATA with `DAn`=0.
- Data-phase length:
  - wait=N with ext_en=0 gives exactly N+1 T2 cycles; wait=0 gives a zero-wait cycle.
  - With ext_en=1, the cycle lasts max(N+1, device ready) cycles.
- `SZRQn`:
  - In T1, `SZRQn` = ~bus16 of the region decoded combinationally from `A`.
  - After T1, it comes from the latched snapshot.
  - It is held for the whole access, including T1S/T2S.
  - `SZRQn` is 1 in ST_IDLE.
- Timeout:
  - Forcing happens on the CE cycle where `tcnt`==`TIMEOUT_CYCLES`.
  - `TIMEOUT`=1 only on that cycle, and only when `rdy`=0.
- Reset: `RES`=1 on a CE cycle puts the FSM in ST_IDLE and reloads the config.
  - After reset: `READYn`=1, `SZRQn`=1, `CS`=0, `CS_RD`=`CS_WR`=0, `TIMEOUT`=0.
  - Reset mid-cycle abandons the cycle; no ready is issued.
- `BCYSTn`=0 together with `DAn`=0 cannot occur in a legal cycle. If it does, T1 handling takes priority.

## Structure
- `v810_pkg` holds:
  - `bus_region_cfg_t` (packed wait/bus16/ext_en);
  - `NUM_BUS_REGIONS`=8;
  - the config reset constant;
  - the FSM enum `bctl_st_t`.
- Sub-module `v810_bus_region_cfg`: 8-entry config register file with a write port and one combinational read port indexed by region.
- `v810_bus_ctrl` holds the FSM, counters, decode and snapshot.

## Test plan
- Reset, then a word read to region 0 with default config: exactly 4 T2 cycles. `READYn`=0 only in the 4th; `SZRQn`=1; `CS`=8'h01.
- Region 7 configured to wait=0, bus16=1; word read at `A`=0x0700_0000: `SZRQn`=0 from T1. Two halfword cycles, each with 1 T2 cycle. `A[1]`=0 then 1.
- Region 2 configured to ext_en=1, wait=1; `DEV_RDYn[2]` held high for 6 cycles: ready in data cycle 7. `TIMEOUT` stays 0.
- `DEV_RDYn` stuck high with ext_en=1: `READYn`=0 and a `TIMEOUT` pulse at data cycle `TIMEOUT_CYCLES`+1 = 256.
- Config write that changes region 0 to wait=0 during a wait=3 cycle: the current cycle still takes 4 T2 cycles; the next cycle takes 1.
- `RES`=1 in the 2nd data cycle: `READYn` and `SZRQn` are 1 on the following cycle, and the config is back to wait=3.
